cpu_ctrl_fsm: RTL and testbench

- Moore state machine that sequences the Simple RISC Machine datapath and memory interface: fetch, PC update, decode, execute, writeback.
- Sits inside cpu between the instruction register/decoder and the datapath, PC and data-address registers.
- Consumes decoded opcode/op fields only. Produces every datapath load/select strobe and the memory command.

---
 rtl/cpu_ctrl_fsm.sv | 118 +++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Moore control FSM for the Simple RISC Machine: fetch, PC update, decode,
// execute and writeback sequencing, with every datapath strobe decoded from state.
module cpu_ctrl_fsm #(
    parameter logic [1:0] MNONE  = 2'b00,
    parameter logic [1:0] MREAD  = 2'b01,
    parameter logic [1:0] MWRITE = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       done,
    output logic       halted,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GA, S_GB, S_MOVC, S_ALU,
        S_CMP, S_WRD, S_ADDR, S_LDA, S_RD1, S_RD2, S_SGB, S_SMOV, S_WR, S_HALT
    } state_t;

    // Instruction class remembered from DEC so shared states (GA, GB, LDA) can branch
    // without looking at opcode/op again.
    typedef enum logic [2:0] {K_MOV, K_ALU, K_CMP, K_LDR, K_STR} kind_t;

    localparam logic [1:0] NSEL_RN = 2'd0, NSEL_RD = 2'd1, NSEL_RM = 2'd2;
    localparam logic [1:0] VSEL_MDATA = 2'd0, VSEL_IMM = 2'd1, VSEL_C = 2'd3;

    state_t cur, nxt;
    kind_t  kind, kind_nxt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= S_RST;
            kind <= K_MOV;
        end else begin
            cur  <= nxt;
            kind <= kind_nxt;
        end
    end

    assign state = cur;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        nxt = cur;
        kind_nxt = kind;
        nsel = NSEL_RN; vsel = VSEL_MDATA; mem_cmd = MNONE;
        loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
        asel = 1'b0; bsel = 1'b0; write = 1'b0; load_ir = 1'b0;
        load_pc = 1'b0; reset_pc = 1'b0; load_addr = 1'b0; addr_sel = 1'b0;
        done = 1'b0; halted = 1'b0;

        unique case (cur)
            S_RST:  begin reset_pc = 1'b1; load_pc = 1'b1; nxt = S_IF1; end
            S_IF1:  begin addr_sel = 1'b1; mem_cmd = MREAD; nxt = S_IF2; end
            S_IF2:  begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; nxt = S_UPC; end
            S_UPC:  begin load_pc = 1'b1; nxt = S_DEC; end
            S_DEC: begin
                unique case ({opcode, op})
                    5'b110_10: nxt = S_WIMM;
                    5'b110_00, 5'b101_11: begin nxt = S_GB; kind_nxt = K_MOV; end
                    5'b101_00, 5'b101_10: begin nxt = S_GA; kind_nxt = K_ALU; end
                    5'b101_01: begin nxt = S_GA; kind_nxt = K_CMP; end
                    5'b011_00: begin nxt = S_GA; kind_nxt = K_LDR; end
                    5'b100_00: begin nxt = S_GA; kind_nxt = K_STR; end
                    default:   nxt = S_HALT;
                endcase
            end
            S_WIMM: begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; done = 1'b1; nxt = S_IF1; end
            S_GA: begin
                nsel = NSEL_RN; loada = 1'b1;
                nxt = (kind == K_LDR || kind == K_STR) ? S_ADDR : S_GB;
            end
            S_GB: begin
                nsel = NSEL_RM; loadb = 1'b1;
                unique case (kind)
                    K_MOV:   nxt = S_MOVC;
                    K_CMP:   nxt = S_CMP;
                    default: nxt = S_ALU;
                endcase
            end
            S_MOVC: begin asel = 1'b1; loadc = 1'b1; nxt = S_WRD; end
            S_ALU:  begin loadc = 1'b1; nxt = S_WRD; end
            S_CMP:  begin loads = 1'b1; done = 1'b1; nxt = S_IF1; end
            S_WRD:  begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; done = 1'b1; nxt = S_IF1; end
            S_ADDR: begin bsel = 1'b1; loadc = 1'b1; nxt = S_LDA; end
            S_LDA:  begin load_addr = 1'b1; nxt = (kind == K_STR) ? S_SGB : S_RD1; end
            S_RD1:  begin mem_cmd = MREAD; nxt = S_RD2; end
            S_RD2: begin
                mem_cmd = MREAD; nsel = NSEL_RD; vsel = VSEL_MDATA;
                write = 1'b1; done = 1'b1; nxt = S_IF1;
            end
            S_SGB:  begin nsel = NSEL_RD; loadb = 1'b1; nxt = S_SMOV; end
            S_SMOV: begin asel = 1'b1; loadc = 1'b1; nxt = S_WR; end
            S_WR:   begin mem_cmd = MWRITE; done = 1'b1; nxt = S_IF1; end
            S_HALT: begin halted = 1'b1; nxt = S_HALT; end
            default: nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: expected state codes are queued per instruction
// and compared, with a table-driven output model, at every falling clock edge.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] nsel, vsel, mem_cmd;
    logic       loada, loadb, loadc, loads, asel, bsel, write, load_ir;
    logic       load_pc, reset_pc, load_addr, addr_sel, done, halted;
    logic [4:0] state;

    cpu_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
        .addr_sel(addr_sel), .mem_cmd(mem_cmd), .done(done), .halted(halted),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [19:0] outs;
    assign outs = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, load_ir,
                   load_pc, reset_pc, load_addr, addr_sel, mem_cmd, done, halted};

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output table written straight from the state list; unknown codes expect all-ones.
    function automatic logic [19:0] model(input logic [4:0] s);
        logic [1:0] ns, vs, mc;
        logic la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, lad, asl, dn, hl;
        {ns, vs, mc} = '0;
        {la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, lad, asl, dn, hl} = '0;
        case (s)
            5'd0:  begin rpc = 1; lpc = 1; end
            5'd1:  begin asl = 1; mc = 2'b01; end
            5'd2:  begin asl = 1; mc = 2'b01; lir = 1; end
            5'd3:  lpc = 1;
            5'd4:  ;
            5'd5:  begin ns = 0; vs = 1; wr = 1; dn = 1; end
            5'd6:  begin ns = 0; la = 1; end
            5'd7:  begin ns = 2; lb = 1; end
            5'd8:  begin as = 1; lc = 1; end
            5'd9:  lc = 1;
            5'd10: begin ls = 1; dn = 1; end
            5'd11: begin ns = 1; vs = 3; wr = 1; dn = 1; end
            5'd12: begin bs = 1; lc = 1; end
            5'd13: lad = 1;
            5'd14: mc = 2'b01;
            5'd15: begin mc = 2'b01; ns = 1; vs = 0; wr = 1; dn = 1; end
            5'd16: begin ns = 1; lb = 1; end
            5'd17: begin as = 1; lc = 1; end
            5'd18: begin mc = 2'b10; dn = 1; end
            5'd19: hl = 1;
            default: return '1;
        endcase
        return {ns, vs, la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, lad, asl, mc, dn, hl};
    endfunction

    task automatic push_body(input logic [2:0] opc, input logic [1:0] o);
        case ({opc, o})
            5'b110_10: exp_q.push_back(5'd5);
            5'b110_00, 5'b101_11: begin exp_q.push_back(5'd7); exp_q.push_back(5'd8); exp_q.push_back(5'd11); end
            5'b101_00, 5'b101_10: begin
                exp_q.push_back(5'd6); exp_q.push_back(5'd7); exp_q.push_back(5'd9); exp_q.push_back(5'd11);
            end
            5'b101_01: begin exp_q.push_back(5'd6); exp_q.push_back(5'd7); exp_q.push_back(5'd10); end
            5'b011_00: begin
                exp_q.push_back(5'd6); exp_q.push_back(5'd12); exp_q.push_back(5'd13);
                exp_q.push_back(5'd14); exp_q.push_back(5'd15);
            end
            5'b100_00: begin
                exp_q.push_back(5'd6); exp_q.push_back(5'd12); exp_q.push_back(5'd13);
                exp_q.push_back(5'd16); exp_q.push_back(5'd17); exp_q.push_back(5'd18);
            end
            default: exp_q.push_back(5'd19);
        endcase
    endtask

    // One falling-edge sample: pop the expectation, compare, then drive the instruction
    // only when DEC is expected and noise everywhere else.
    task automatic step(input logic [2:0] opc, input logic [1:0] o, output logic [4:0] e);
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'd31;
        check("state", 32'(state), 32'(e));
        check("outputs", 32'(outs), 32'(model(e)));
        if (e == 5'd4) begin
            opcode = opc; op = o;
        end else begin
            opcode = 3'($urandom_range(7)); op = 2'($urandom_range(3));
        end
    endtask

    // Entered with IF1 just sampled; runs until the DUT is back in IF1.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int exp_cycles);
        logic [4:0] e;
        int n = 0;
        int dones = 0;
        exp_q.push_back(5'd2); exp_q.push_back(5'd3); exp_q.push_back(5'd4);
        push_body(opc, o);
        exp_q.push_back(5'd1);
        do begin
            step(opc, o, e);
            n++;
            dones += int'(done);
        end while (state != 5'd1 && n < 40);
        check("cycles", 32'(n), 32'(exp_cycles));
        check("done_count", 32'(dones), 32'd1);
        exp_q.delete();
    endtask

    // Reset asserted mid clock-low must act before the next rising edge; released on a
    // falling edge, after which the following sample must be IF1.
    task automatic async_reset_and_refetch();
        #3 reset = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", 32'(outs), 32'(model(5'd0)));
        @(negedge clk);
        check("rst_hold", 32'(state), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("refetch_state", 32'(state), 32'd1);
        check("refetch_outputs", 32'(outs), 32'(model(5'd1)));
    endtask

    task automatic run_halt(input logic [2:0] opc, input logic [1:0] o);
        logic [4:0] e;
        exp_q.push_back(5'd2); exp_q.push_back(5'd3); exp_q.push_back(5'd4);
        for (int i = 0; i < 25; i++) exp_q.push_back(5'd19);
        while (exp_q.size() != 0) step(opc, o, e);
        async_reset_and_refetch();
    endtask

    initial begin
        logic [4:0] e;
        reset = 1'b1; opcode = '0; op = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs", 32'(outs), 32'(model(5'd0)));
        reset = 1'b0;
        @(negedge clk);
        check("if1_state", 32'(state), 32'd1);
        check("if1_outputs", 32'(outs), 32'(model(5'd1)));

        run_instr(3'b110, 2'b10, 5);   // MOV imm
        run_instr(3'b101, 2'b00, 8);   // ADD
        run_instr(3'b101, 2'b01, 7);   // CMP
        run_instr(3'b101, 2'b11, 7);   // MVN
        run_instr(3'b110, 2'b00, 7);   // MOV reg
        run_instr(3'b101, 2'b10, 8);   // AND
        run_instr(3'b011, 2'b00, 9);   // LDR
        run_instr(3'b100, 2'b00, 10);  // STR
        run_instr(3'b110, 2'b10, 5);   // MOV imm after a memory op

        // LDR interrupted by reset while in RD1.
        exp_q.push_back(5'd2); exp_q.push_back(5'd3); exp_q.push_back(5'd4);
        exp_q.push_back(5'd6); exp_q.push_back(5'd12); exp_q.push_back(5'd13); exp_q.push_back(5'd14);
        while (exp_q.size() != 0) step(3'b011, 2'b00, e);
        async_reset_and_refetch();

        run_halt(3'b111, 2'b00);       // HALT
        run_halt(3'b000, 2'b00);       // undefined
        run_halt(3'b110, 2'b11);       // undefined
        run_instr(3'b101, 2'b01, 7);   // CMP after leaving HALT

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
